// File: rtl/kick_trigger.sv
// Kick command front end: immediate or breakbeam-armed kick, one-cycle strobe to the kicker.
// Latency: strobe 1 cycle after the launching edge; holds off new kicks until fire/lockout clears.
module kick_trigger #(
  parameter int unsigned PRESCALE_DIV    = 575,
  parameter int unsigned DEBOUNCE_CYCLES = 64,
  parameter int unsigned ARM_TIMEOUT     = 8191,
  parameter int unsigned ACK_WINDOW      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_strength,
  input  logic       breakbeam,
  input  logic       kicker_fire,
  input  logic       kicker_lockout,
  output logic       strobe,
  output logic [7:0] strength,
  output logic       armed,
  output logic       ball_present,
  output logic       busy,
  output logic       kick_dropped,
  output logic       arm_expired
);

  localparam logic [9:0]  PRESC_LAST = 10'(PRESCALE_DIV);
  localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(ARM_TIMEOUT);
  localparam logic [7:0]  ACK_LAST   = 8'(ACK_WINDOW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRE_WAIT,
    ST_COOLDOWN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic [7:0]  r_deb_cnt;
  logic        r_ball;
  logic [9:0]  r_presc;
  logic [15:0] r_timeout;
  logic [7:0]  r_arm_str;
  logic [7:0]  r_ack_cnt;
  logic        r_strobe;
  logic [7:0]  r_strength;
  logic        r_drop;
  logic        r_expired;

  logic        w_tick;
  logic        w_cmd_cancel;
  logic        w_cmd_fire;
  logic        w_cmd_arm;
  logic        w_launch;
  logic [7:0]  w_launch_str;
  logic        w_rearm;
  logic        w_drop;
  logic        w_expire;

  assign w_tick       = (r_state == ST_ARMED) && (r_presc == PRESC_LAST);
  assign w_cmd_cancel = cmd_valid && (cmd_mode == 2'd0);
  assign w_cmd_fire   = cmd_valid && (cmd_mode == 2'd1);
  assign w_cmd_arm    = cmd_valid && (cmd_mode == 2'd2);

  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_launch_str = r_arm_str;
    w_rearm      = 1'b0;
    w_drop       = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A kicker still in lockout rejects an immediate kick rather than stalling it.
        if (w_cmd_fire) begin
          if (kicker_lockout) begin
            w_drop = 1'b1;
          end else begin
            w_launch     = 1'b1;
            w_launch_str = cmd_strength;
          end
        end else if (w_cmd_arm) begin
          w_rearm     = 1'b1;
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_cmd_cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cmd_fire) begin
          if (kicker_lockout) begin
            w_drop = 1'b1;
          end else begin
            w_launch     = 1'b1;
            w_launch_str = cmd_strength;
          end
        end else if (w_cmd_arm) begin
          w_rearm = 1'b1;
        end else if (r_ball && !kicker_lockout) begin
          w_launch = 1'b1;
        end else if (w_tick && (r_timeout == TO_LAST)) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FIRE_WAIT: begin
        if (kicker_fire) begin
          w_state_nxt = ST_COOLDOWN;
        end else if (r_ack_cnt == ACK_LAST) begin
          w_drop      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        if (w_cmd_fire || w_cmd_arm) begin
          w_drop = 1'b1;
        end
      end
      default: begin
        if (!kicker_fire && !kicker_lockout) begin
          w_state_nxt = ST_IDLE;
        end
        if (w_cmd_fire || w_cmd_arm) begin
          w_drop = 1'b1;
        end
      end
    endcase
    if (w_launch) begin
      w_state_nxt = ST_FIRE_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb_cnt  <= 8'd0;
      r_ball     <= 1'b0;
      r_presc    <= 10'd0;
      r_timeout  <= 16'd0;
      r_arm_str  <= 8'd0;
      r_ack_cnt  <= 8'd0;
      r_strobe   <= 1'b0;
      r_strength <= 8'd0;
      r_drop     <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= breakbeam;
      r_sync2 <= r_sync1;

      if (r_sync2 == r_ball) begin
        r_deb_cnt <= 8'd0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_ball    <= r_sync2;
        r_deb_cnt <= 8'd0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 8'd1;
      end

      if (w_rearm || (r_state != ST_ARMED) || (w_state_nxt != ST_ARMED)) begin
        r_presc <= 10'd0;
      end else begin
        r_presc <= w_tick ? 10'd0 : r_presc + 10'd1;
      end

      // Holding at the limit lets a blocked expiry land on the following tick.
      if (w_rearm || (r_state != ST_ARMED)) begin
        r_timeout <= 16'd0;
      end else if (w_tick && (r_timeout != TO_LAST)) begin
        r_timeout <= r_timeout + 16'd1;
      end

      if (w_rearm) begin
        r_arm_str <= cmd_strength;
      end

      r_ack_cnt <= (r_state == ST_FIRE_WAIT) ? r_ack_cnt + 8'd1 : 8'd0;

      r_strobe <= w_launch;
      if (w_launch) begin
        r_strength <= w_launch_str;
      end
      r_drop    <= w_drop;
      r_expired <= w_expire;
    end
  end

  assign strobe       = r_strobe;
  assign strength     = r_strength;
  assign armed        = (r_state == ST_ARMED);
  assign ball_present = r_ball;
  assign busy         = (r_state == ST_FIRE_WAIT) || (r_state == ST_COOLDOWN);
  assign kick_dropped = r_drop;
  assign arm_expired  = r_expired;

endmodule

// File: tb/tb_kick_trigger.sv
// Bench for kick_trigger: directed scenarios plus random traffic against a deadline-based reference model.
module tb_kick_trigger;

  localparam int PD    = 15;
  localparam int DEB   = 64;
  localparam int TO    = 5;
  localparam int ACK   = 3;
  localparam int N_EXP = (TO + 1) * (PD + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_strength;
  logic       breakbeam;
  logic       kicker_fire;
  logic       kicker_lockout;
  logic       strobe;
  logic [7:0] strength;
  logic       armed;
  logic       ball_present;
  logic       busy;
  logic       kick_dropped;
  logic       arm_expired;

  int vectors = 0;
  int miscompares = 0;

  kick_trigger #(
    .PRESCALE_DIV(PD), .DEBOUNCE_CYCLES(DEB), .ARM_TIMEOUT(TO), .ACK_WINDOW(ACK)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_strength(cmd_strength), .breakbeam(breakbeam), .kicker_fire(kicker_fire),
    .kicker_lockout(kicker_lockout), .strobe(strobe), .strength(strength), .armed(armed),
    .ball_present(ball_present), .busy(busy), .kick_dropped(kick_dropped),
    .arm_expired(arm_expired)
  );

  always #5 clk = ~clk;

  // Reference model: timeouts are expressed as edge counts since entering a phase.
  typedef enum {M_IDLE, M_ARMED, M_FIRE_WAIT, M_COOLDOWN} mphase_t;
  mphase_t    m_ph = M_IDLE;
  bit         bb_q[$] = '{1'b0, 1'b0};
  bit         m_bp = 1'b0;
  int         m_run = 0;
  int         m_age = 0;
  logic [7:0] m_arm_str = 8'd0;
  logic       e_strobe = 1'b0, e_drop = 1'b0, e_exp = 1'b0;
  logic [7:0] e_strength = 8'd0;

  always @(posedge clk) begin : model
    bit         s, launch, drop, expire, c_fire, c_arm, c_cancel;
    logic [7:0] lstr;
    mphase_t    nx;
    if (!rst_n) begin
      m_ph = M_IDLE; bb_q = '{1'b0, 1'b0}; m_bp = 1'b0; m_run = 0; m_age = 0;
      m_arm_str = 8'd0; e_strobe = 1'b0; e_drop = 1'b0; e_exp = 1'b0; e_strength = 8'd0;
    end else begin
      s = bb_q.pop_front();
      bb_q.push_back(breakbeam);
      c_fire   = cmd_valid && cmd_mode == 2'd1;
      c_arm    = cmd_valid && cmd_mode == 2'd2;
      c_cancel = cmd_valid && cmd_mode == 2'd0;
      nx = m_ph; launch = 0; drop = 0; expire = 0; lstr = m_arm_str;
      case (m_ph)
        M_IDLE: begin
          if (c_fire) begin
            if (kicker_lockout) drop = 1; else begin launch = 1; lstr = cmd_strength; end
          end else if (c_arm) begin
            nx = M_ARMED; m_age = 0; m_arm_str = cmd_strength;
          end
        end
        M_ARMED: begin
          m_age++;
          if (c_cancel) nx = M_IDLE;
          else if (c_fire) begin
            if (kicker_lockout) drop = 1; else begin launch = 1; lstr = cmd_strength; end
          end else if (c_arm) begin
            m_age = 0; m_arm_str = cmd_strength;
          end else if (m_bp && !kicker_lockout) launch = 1;
          else if (m_age >= N_EXP && ((m_age - N_EXP) % (PD + 1)) == 0) begin
            expire = 1; nx = M_IDLE;
          end
        end
        M_FIRE_WAIT: begin
          m_age++;
          if (kicker_fire) nx = M_COOLDOWN;
          else if (m_age == ACK) begin drop = 1; nx = M_IDLE; end
          if (c_fire || c_arm) drop = 1;
        end
        M_COOLDOWN: begin
          if (!kicker_fire && !kicker_lockout) nx = M_IDLE;
          if (c_fire || c_arm) drop = 1;
        end
      endcase
      if (launch) begin nx = M_FIRE_WAIT; m_age = 0; e_strength = lstr; end
      e_strobe = launch; e_drop = drop; e_exp = expire; m_ph = nx;
      if (s != m_bp) begin
        m_run++;
        if (m_run == DEB) begin m_bp = s; m_run = 0; end
      end else m_run = 0;
    end
  end

  // Behavioural kicker: fires for two cycles after a strobe, then stays in lockout.
  bit k_en = 1'b1;
  bit k_active = 1'b0;
  int k_age = 0;
  int k_lock = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v = 1'b0, input logic [1:0] m = 2'd0, input logic [7:0] st = 8'd0);
    cmd_valid = v; cmd_mode = m; cmd_strength = st;
    @(posedge clk); #1;
    vectors++;
    chk("strobe", 32'(strobe), 32'(e_strobe));
    chk("strength", 32'(strength), 32'(e_strength));
    chk("armed", 32'(armed), 32'(m_ph == M_ARMED));
    chk("ball_present", 32'(ball_present), 32'(m_bp));
    chk("busy", 32'(busy), 32'(m_ph == M_FIRE_WAIT || m_ph == M_COOLDOWN));
    chk("kick_dropped", 32'(kick_dropped), 32'(e_drop));
    chk("arm_expired", 32'(arm_expired), 32'(e_exp));
    if (!rst_n) k_active = 1'b0;
    if (k_active) k_age++;
    if (strobe && k_en && rst_n) begin k_active = 1'b1; k_age = 0; end
    kicker_fire    = k_active && k_age >= 1 && k_age <= 2;
    kicker_lockout = k_active && k_age >= 1 && k_age <= k_lock;
    if (k_active && k_age > k_lock) k_active = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || armed) && n < 200) begin step(); n++; end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    int bb_hold;
    bit seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_strength = 8'd0;
    breakbeam = 1'b0; kicker_fire = 1'b0; kicker_lockout = 1'b0;
    repeat (3) step();
    chk("rst_outputs", {24'd0, strobe, armed, ball_present, busy, kick_dropped, arm_expired, 2'b00}, 32'd0);
    chk("rst_strength", 32'(strength), 32'd0);
    rst_n = 1'b1;
    step();

    // Immediate kick.
    k_lock = 6;
    step(1'b1, 2'd1, 8'h80);
    chk("imm_strobe", 32'({strobe, busy}), 32'h3);
    chk("imm_strength", 32'(strength), 32'h80);
    step();
    chk("imm_strobe_once", 32'(strobe), 32'd0);
    wait_idle("imm_idle_bound");

    // Armed kick: ball arrives after arming.
    step(1'b1, 2'd2, 8'h40);
    breakbeam = 1'b1;
    n = 0;
    while (!ball_present && n < 200) begin step(); n++; end
    chk("bp_latency", n, 32'd66);
    step();
    chk("armed_strobe", 32'({strobe, armed}), 32'h2);
    chk("armed_strength", 32'(strength), 32'h40);
    wait_idle("armed_idle_bound");
    repeat (30) step();
    breakbeam = 1'b0;
    n = 0;
    while (ball_present && n < 200) begin step(); n++; end
    chk("bp_fall_bound", 32'(n < 200), 32'd1);

    // Short glitches while armed, then cancel.
    step(1'b1, 2'd2, 8'h21);
    seen = 1'b0;
    for (int g = 0; g < 2; g++) begin
      breakbeam = 1'b1;
      repeat (30) begin step(); seen |= strobe | ball_present; end
      breakbeam = 1'b0;
      repeat (10) begin step(); seen |= strobe | ball_present; end
    end
    chk("glitch_ignored", 32'(seen), 32'd0);
    step(1'b1, 2'd0, 8'h00);
    chk("cancel", 32'({armed, kick_dropped, arm_expired}), 32'd0);
    step();

    // Arm timeout.
    step(1'b1, 2'd2, 8'h11);
    n = 0;
    while (!arm_expired && n < 200) begin step(); n++; end
    chk("expire_latency", n, 32'(N_EXP));
    chk("expire_state", 32'({armed, strobe}), 32'd0);
    step();

    // Command during cooldown.
    k_lock = 20;
    step(1'b1, 2'd1, 8'h22);
    repeat (5) step();
    step(1'b1, 2'd1, 8'h33);
    chk("cool_drop", 32'({kick_dropped, strobe, busy}), 32'h5);
    chk("cool_strength", 32'(strength), 32'h22);
    wait_idle("cool_idle_bound");

    // No acknowledge from the kicker.
    k_en = 1'b0;
    step(1'b1, 2'd1, 8'h99);
    n = 0;
    while (!kick_dropped && n < 50) begin step(); n++; end
    chk("ack_timeout", n, 32'd3);
    chk("ack_idle", 32'(busy), 32'd0);
    k_en = 1'b1;
    step();

    // Reset during cooldown.
    step(1'b1, 2'd1, 8'h55);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("rst_cool", {23'd0, strength, strobe}, 32'd0);
    chk("rst_cool_flags", 32'({armed, ball_present, busy, kick_dropped, arm_expired}), 32'd0);
    rst_n = 1'b1;
    step();

    // Random traffic.
    bb_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bb_hold == 0) begin
        breakbeam = ($urandom_range(0, 1) == 1);
        bb_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(60, 150);
      end
      bb_hold--;
      k_en = ($urandom_range(0, 4) != 0);
      if (!k_active) k_lock = $urandom_range(2, 10);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0)
        step(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      else
        step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
